// File: rtl/inst_encoder_pkg.sv
// Shared instruction-format definitions: opcode enum, field positions and
// opcode class helpers used by both the encoder and the ID-stage decoder.
package inst_encoder_pkg;

  typedef enum logic [5:0] {
    OP_ADD  = 6'h00, OP_ADDI = 6'h01, OP_SUB  = 6'h02, OP_SUBI = 6'h03,
    OP_MUL  = 6'h04, OP_MULI = 6'h05, OP_OR   = 6'h06, OP_ORI  = 6'h07,
    OP_AND  = 6'h08, OP_ANDI = 6'h09, OP_XOR  = 6'h0A, OP_XORI = 6'h0B,
    OP_LDW  = 6'h0C, OP_STW  = 6'h0D, OP_BZ   = 6'h0E, OP_BEQ  = 6'h0F,
    OP_JR   = 6'h10, OP_HALT = 6'h11
  } op_e;

  localparam logic [5:0] OP_MAX = 6'h11;

  localparam int OP_LSB  = 26;
  localparam int RS_LSB  = 21;
  localparam int RT_LSB  = 16;
  localparam int RD_LSB  = 11;
  localparam int IMM_LSB = 0;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  // R-type ops are the even opcodes from ADD through XOR
  function automatic logic is_rtype(input logic [5:0] op);
    return (op <= 6'h0A) && !op[0];
  endfunction

  function automatic logic is_itype(input logic [5:0] op);
    logic r;
    r = 1'b0;
    case (op)
      OP_ADDI, OP_SUBI, OP_MULI, OP_ORI, OP_ANDI, OP_XORI,
      OP_LDW, OP_STW, OP_BEQ: r = 1'b1;
      default:                r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/inst_encoder_sync_fifo.sv
// Synchronous FIFO with full/empty flags; pushes while full and pops while
// empty are dropped so callers may gate loosely.
module sync_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr;
  logic [AW-1:0]    rptr;
  logic [AW:0]      cnt;
  logic             do_push;
  logic             do_pop;

  assign full    = (cnt == FULL_CNT);
  assign empty   = (cnt == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rptr];

  always_ff @(posedge clk) begin
    if (reset) begin
      wptr <= '0;
      rptr <= '0;
      cnt  <= '0;
    end else begin
      if (do_push) begin
        mem[wptr] <= wdata;
        wptr      <= wptr + 1'b1;
      end
      if (do_pop) rptr <= rptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: rtl/inst_encoder.sv
// Encodes field-level instruction requests into 32-bit words and streams them
// through a FIFO into instruction memory starting at a base word address.
//
//   state    | meaning
//   ST_IDLE  | waiting for start after reset
//   ST_LOAD  | accepting requests, writing words
//   ST_DRAIN | HALT accepted, flushing remaining FIFO words to imem
//   ST_DONE  | load finished; start begins a new load
module inst_encoder
  import inst_encoder_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int ADDR_W     = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [5:0]        req_op,
  input  logic [4:0]        req_rs,
  input  logic [4:0]        req_rt,
  input  logic [4:0]        req_rd,
  input  logic [31:0]       req_imm,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  input  logic              imem_ready,
  output logic              busy,
  output logic              done,
  output logic              err_illegal,
  output logic              err_imm,
  output logic [ADDR_W-1:0] inst_count
);

  state_e      state, state_nxt;
  logic        fifo_full, fifo_empty;
  logic [31:0] fifo_head;
  logic [31:0] enc_word;
  logic        accept, push, pop, load_start, fifo_reset;
  logic        op_illegal, needs_imm, imm_fits, imm_bad;

  function automatic logic [31:0] encode(input logic [5:0]  op,
                                         input logic [4:0]  rs,
                                         input logic [4:0]  rt,
                                         input logic [4:0]  rd,
                                         input logic [15:0] imm);
    logic [31:0] w;
    w = '0;
    w[OP_LSB +: 6] = op;
    if (is_rtype(op)) begin
      w[RS_LSB +: 5] = rs;
      w[RT_LSB +: 5] = rt;
      w[RD_LSB +: 5] = rd;
    end else if (is_itype(op)) begin
      w[RS_LSB +: 5]   = rs;
      w[RT_LSB +: 5]   = rt;
      w[IMM_LSB +: 16] = imm;
    end else if (op == OP_BZ) begin
      w[RS_LSB +: 5]   = rs;
      w[IMM_LSB +: 16] = imm;
    end else if (op == OP_JR) begin
      w[RS_LSB +: 5] = rs;
    end
    return w;
  endfunction

  assign op_illegal = (req_op > OP_MAX);
  assign needs_imm  = is_itype(req_op) || (req_op == OP_BZ);
  // Upper 17 bits must be pure sign extension of bit 15
  assign imm_fits   = (req_imm[31:15] == '0) || (req_imm[31:15] == '1);
  assign imm_bad    = needs_imm && !imm_fits;
  assign enc_word   = encode(req_op, req_rs, req_rt, req_rd, req_imm[15:0]);

  assign req_ready  = (state == ST_LOAD) && !fifo_full;
  assign accept     = req_valid && req_ready;
  assign push       = accept && !op_illegal && !imm_bad;
  assign load_start = start && ((state == ST_IDLE) || (state == ST_DONE));
  assign fifo_reset = reset || load_start;

  assign imem_we    = !fifo_empty && ((state == ST_LOAD) || (state == ST_DRAIN));
  assign imem_wdata = imem_we ? fifo_head : '0;
  assign pop        = imem_we && imem_ready;
  assign busy       = (state == ST_LOAD) || (state == ST_DRAIN);
  assign done       = (state == ST_DONE);

  sync_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(32)) u_fifo (
    .clk   (clk),
    .reset (fifo_reset),
    .push  (push),
    .wdata (enc_word),
    .pop   (pop),
    .rdata (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (start) state_nxt = ST_LOAD;
      ST_LOAD:  if (accept && (req_op == OP_HALT)) state_nxt = ST_DRAIN;
      ST_DRAIN: if (fifo_empty) state_nxt = ST_DONE;
      ST_DONE:  if (start) state_nxt = ST_LOAD;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ST_IDLE;
      imem_addr   <= '0;
      inst_count  <= '0;
      err_illegal <= 1'b0;
      err_imm     <= 1'b0;
    end else begin
      state <= state_nxt;
      if (load_start) begin
        imem_addr   <= base_addr;
        inst_count  <= '0;
        err_illegal <= 1'b0;
        err_imm     <= 1'b0;
      end else begin
        if (pop) begin
          imem_addr  <= imem_addr + 1'b1;
          inst_count <= inst_count + 1'b1;
        end
        if (accept && op_illegal) err_illegal <= 1'b1;
        if (accept && !op_illegal && imm_bad) err_imm <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_inst_encoder.sv
// Directed bench for inst_encoder: table-driven encoding vectors plus
// hand-written backpressure, address-wrap and reset-in-drain sequences.
module tb_inst_encoder;

  localparam int ADDR_W = 10;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              start = 1'b0;
  logic [ADDR_W-1:0] base_addr = '0;
  logic              req_valid = 1'b0;
  logic              req_ready;
  logic [5:0]        req_op = '0;
  logic [4:0]        req_rs = '0, req_rt = '0, req_rd = '0;
  logic [31:0]       req_imm = '0;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;
  logic              imem_ready = 1'b1;
  logic              busy, done, err_illegal, err_imm;
  logic [ADDR_W-1:0] inst_count;

  int tests = 0;
  int fails = 0;

  logic [ADDR_W-1:0] log_addr[$];
  logic [31:0]       log_data[$];

  typedef struct {
    logic [5:0]  op;
    logic [4:0]  rs, rt, rd;
    logic [31:0] imm;
    bit          wr;
    logic [31:0] word;
  } vec_t;

  vec_t vecs[10];

  inst_encoder #(.FIFO_DEPTH(4), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .reset(reset), .start(start), .base_addr(base_addr),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_rs(req_rs), .req_rt(req_rt), .req_rd(req_rd), .req_imm(req_imm),
    .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .imem_ready(imem_ready), .busy(busy), .done(done),
    .err_illegal(err_illegal), .err_imm(err_imm), .inst_count(inst_count)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (imem_we === 1'b1 && imem_ready === 1'b1) begin
      log_addr.push_back(imem_addr);
      log_data.push_back(imem_wdata);
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic do_start(input logic [ADDR_W-1:0] b);
    req_valid = 1'b0;
    base_addr = b;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Called at a negedge; returns at the negedge after acceptance with valid still high
  task automatic send(input logic [5:0] op, input logic [4:0] rs, input logic [4:0] rt,
                      input logic [4:0] rd, input logic [31:0] imm);
    int n;
    req_op = op; req_rs = rs; req_rt = rt; req_rd = rd; req_imm = imm;
    req_valid = 1'b1;
    n = 0;
    while (req_ready !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) begin
      tests++; fails++;
      $display("FAIL send_timeout: req_ready stuck at %b, required 1", req_ready);
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic wait_done();
    int n;
    req_valid = 1'b0;
    n = 0;
    while (done !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("done_reached", {31'b0, done}, 32'h1);
  endtask

  task automatic chk_log(input string name, input logic [ADDR_W-1:0] base,
                         input logic [31:0] exp_words[$]);
    chk({name, "_len"}, log_data.size(), exp_words.size());
    for (int i = 0; i < exp_words.size() && i < log_data.size(); i++) begin
      chk({name, "_addr"}, {22'b0, log_addr[i]}, {22'b0, base + ADDR_W'(i)});
      chk({name, "_data"}, log_data[i], exp_words[i]);
    end
  endtask

  initial begin
    logic [31:0] exp_q[$];
    int hold_bad;

    // op, rs, rt, rd, imm, written, word
    vecs[0] = '{6'h01, 5'd1,  5'd4, 5'd0,  32'hFFFF_FFFF, 1'b1, 32'h0424_FFFF};
    vecs[1] = '{6'h01, 5'd1,  5'd4, 5'd0,  32'h0000_8000, 1'b0, 32'h0};
    vecs[2] = '{6'h20, 5'd1,  5'd2, 5'd3,  32'h0,         1'b0, 32'h0};
    vecs[3] = '{6'h00, 5'd1,  5'd2, 5'd3,  32'h0,         1'b1, 32'h0022_1800};
    vecs[4] = '{6'h02, 5'd5,  5'd6, 5'd7,  32'h0,         1'b1, 32'h08A6_3800};
    vecs[5] = '{6'h0E, 5'd3,  5'd9, 5'd1,  32'h0000_1234, 1'b1, 32'h3860_1234};
    vecs[6] = '{6'h10, 5'd31, 5'd7, 5'd7,  32'h1234_5678, 1'b1, 32'h43E0_0000};
    vecs[7] = '{6'h0C, 5'd2,  5'd3, 5'd0,  32'hFFFF_8000, 1'b1, 32'h3043_8000};
    vecs[8] = '{6'h0B, 5'd0,  5'd1, 5'd0,  32'h0000_7FFF, 1'b1, 32'h2C01_7FFF};
    vecs[9] = '{6'h00, 5'd0,  5'd0, 5'd31, 32'h1234_5678, 1'b1, 32'h0000_F800};

    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    chk("rst_busy",       {31'b0, busy},        32'h0);
    chk("rst_done",       {31'b0, done},        32'h0);
    chk("rst_req_ready",  {31'b0, req_ready},   32'h0);
    chk("rst_imem_we",    {31'b0, imem_we},     32'h0);
    chk("rst_imem_addr",  {22'b0, imem_addr},   32'h0);
    chk("rst_inst_count", {22'b0, inst_count},  32'h0);
    chk("rst_err_ill",    {31'b0, err_illegal}, 32'h0);
    chk("rst_err_imm",    {31'b0, err_imm},     32'h0);

    // Basic load: ADD then HALT at base 0x010
    log_addr.delete(); log_data.delete();
    do_start(10'h010);
    chk("load_busy", {31'b0, busy}, 32'h1);
    send(6'h00, 5'd1, 5'd2, 5'd3, 32'h0);
    chk("lat_we",    {31'b0, imem_we}, 32'h1);
    chk("lat_wdata", imem_wdata, 32'h0022_1800);
    send(6'h11, 5'd0, 5'd0, 5'd0, 32'h0);
    wait_done();
    exp_q = '{32'h0022_1800, 32'h4400_0000};
    chk_log("basic", 10'h010, exp_q);
    chk("basic_count", {22'b0, inst_count}, 32'h2);
    chk("basic_busy",  {31'b0, busy}, 32'h0);

    // Table-driven encodings, including dropped illegal/out-of-range requests
    log_addr.delete(); log_data.delete();
    exp_q.delete();
    do_start(10'h020);
    for (int i = 0; i < 10; i++) begin
      send(vecs[i].op, vecs[i].rs, vecs[i].rt, vecs[i].rd, vecs[i].imm);
      if (vecs[i].wr) exp_q.push_back(vecs[i].word);
    end
    send(6'h11, 5'd3, 5'd3, 5'd3, 32'hFFFF_FFFF);
    exp_q.push_back(32'h4400_0000);
    wait_done();
    chk_log("table", 10'h020, exp_q);
    chk("table_count",   {22'b0, inst_count}, 32'h9);
    chk("table_err_ill", {31'b0, err_illegal}, 32'h1);
    chk("table_err_imm", {31'b0, err_imm}, 32'h1);

    // Backpressure: memory stalls, FIFO fills, order preserved
    log_addr.delete(); log_data.delete();
    exp_q.delete();
    imem_ready = 1'b0;
    do_start(10'h100);
    chk("restart_err_ill", {31'b0, err_illegal}, 32'h0);
    chk("restart_err_imm", {31'b0, err_imm}, 32'h0);
    chk("restart_done",    {31'b0, done}, 32'h0);
    for (int k = 1; k <= 4; k++) begin
      send(6'h00, 5'd1, 5'd0, 5'(k), 32'h0);
      exp_q.push_back(32'h0020_0000 | (32'(k) << 11));
    end
    req_rd = 5'd5;
    chk("full_ready",  {31'b0, req_ready}, 32'h0);
    chk("full_we",     {31'b0, imem_we}, 32'h1);
    chk("full_head",   imem_wdata, 32'h0020_0800);
    hold_bad = 0;
    repeat (5) begin
      @(negedge clk);
      if (req_ready !== 1'b0) hold_bad++;
    end
    chk("full_hold", hold_bad, 0);
    imem_ready = 1'b1;
    chk("no_bypass", {31'b0, req_ready}, 32'h0);
    for (int k = 5; k <= 6; k++) begin
      send(6'h00, 5'd1, 5'd0, 5'(k), 32'h0);
      exp_q.push_back(32'h0020_0000 | (32'(k) << 11));
    end
    send(6'h11, 5'd0, 5'd0, 5'd0, 32'h0);
    exp_q.push_back(32'h4400_0000);
    wait_done();
    chk_log("bp", 10'h100, exp_q);
    chk("bp_count", {22'b0, inst_count}, 32'h7);

    // Address wrap; a start pulse mid-load must be ignored
    log_addr.delete(); log_data.delete();
    exp_q.delete();
    do_start(10'h3FF);
    send(6'h00, 5'd2, 5'd2, 5'd1, 32'h0);
    exp_q.push_back(32'h0042_0800);
    do_start(10'h055);
    send(6'h00, 5'd2, 5'd2, 5'd2, 32'h0);
    exp_q.push_back(32'h0042_1000);
    send(6'h11, 5'd0, 5'd0, 5'd0, 32'h0);
    exp_q.push_back(32'h4400_0000);
    wait_done();
    chk_log("wrap", 10'h3FF, exp_q);
    chk("wrap_count", {22'b0, inst_count}, 32'h3);

    // Reset while draining with two words queued
    imem_ready = 1'b0;
    do_start(10'h200);
    send(6'h3F, 5'd0, 5'd0, 5'd0, 32'h0);
    send(6'h00, 5'd1, 5'd2, 5'd3, 32'h0);
    send(6'h11, 5'd0, 5'd0, 5'd0, 32'h0);
    req_valid = 1'b0;
    chk("drain_busy",  {31'b0, busy}, 32'h1);
    chk("drain_we",    {31'b0, imem_we}, 32'h1);
    chk("drain_err",   {31'b0, err_illegal}, 32'h1);
    log_addr.delete(); log_data.delete();
    reset = 1'b1;
    @(negedge clk);
    chk("rd_we",       {31'b0, imem_we}, 32'h0);
    chk("rd_busy",     {31'b0, busy}, 32'h0);
    chk("rd_done",     {31'b0, done}, 32'h0);
    chk("rd_addr",     {22'b0, imem_addr}, 32'h0);
    chk("rd_count",    {22'b0, inst_count}, 32'h0);
    chk("rd_err_ill",  {31'b0, err_illegal}, 32'h0);
    chk("rd_wdata",    imem_wdata, 32'h0);
    reset = 1'b0;
    imem_ready = 1'b1;
    repeat (5) @(negedge clk);
    chk("rd_no_writes", log_data.size(), 0);
    chk("rd_idle_ready", {31'b0, req_ready}, 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
